// File: rtl/simple_counter_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : simple_counter_scheduler
// Brief    : Round-robin arbiter that lends one shared counter to NUM_REQ
//            requesters for windows of exactly N enable cycles.
// Revision : 1.0 - initial release
// ============================================================================
module simple_counter_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*LEN_W-1:0] len_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic [NUM_REQ-1:0]       done_o,
    output logic                     abort_o,
    output logic                     wrap_o,
    output logic [CNT_W-1:0]         start_count_o,
    output logic                     busy_o,
    output logic                     enable_o,
    input  logic [CNT_W-1:0]         count_value_i,
    input  logic                     overflow_i
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [c_IDX_W-1:0]   r_gnt_idx;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [LEN_W-1:0]     r_remaining;
    logic [CNT_W-1:0]     r_start;
    logic                 r_wrap;
    logic                 r_abort;

    logic                 w_found;
    logic [c_IDX_W-1:0]   w_gnt_idx;
    logic [c_IDX_W-1:0]   w_cand_idx;
    logic [c_IDX_W-1:0]   w_ptr_nxt;
    logic [LEN_W-1:0]     w_len_sel;
    logic [NUM_REQ-1:0]   w_onehot;
    logic                 w_load;
    logic                 w_abort_set;
    int                   w_cand;

    // Rotating search: first requester at or after the pointer wins.
    always_comb begin
        w_found    = 1'b0;
        w_gnt_idx  = '0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = int'(r_rr_ptr) + i;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            w_cand_idx = c_IDX_W'(w_cand);
            if (!w_found && req_i[w_cand_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand_idx;
            end
        end
    end

    always_comb begin
        w_len_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (c_IDX_W'(k) == w_gnt_idx) begin
                w_len_sel = len_i[k*LEN_W +: LEN_W];
            end
        end
        w_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_gnt_idx;
        w_ptr_nxt = (int'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_abort_set = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_load      = 1'b1;
                    w_state_nxt = (w_len_sel != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                // A withdrawn request ends the window early regardless of remaining.
                if (!req_i[r_gnt_idx]) begin
                    w_state_nxt = DONE;
                    w_abort_set = 1'b1;
                end else if (r_remaining == LEN_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_gnt_idx   <= '0;
            r_rr_ptr    <= '0;
            r_remaining <= '0;
            r_start     <= '0;
            r_wrap      <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_grant     <= w_onehot;
                r_gnt_idx   <= w_gnt_idx;
                r_remaining <= w_len_sel;
                r_start     <= count_value_i;
                r_wrap      <= 1'b0;
                r_abort     <= 1'b0;
                r_rr_ptr    <= w_ptr_nxt;
            end else begin
                if (r_state == RUN) begin
                    r_remaining <= r_remaining - 1'b1;
                end
                if (w_abort_set) begin
                    r_abort <= 1'b1;
                end
                if (r_state == DONE) begin
                    r_grant <= '0;
                end
                // DONE is included so a late-registered overflow is still caught.
                if (overflow_i && (r_state == RUN || r_state == DONE)) begin
                    r_wrap <= 1'b1;
                end
            end
        end
    end

    assign grant_o       = r_grant;
    assign done_o        = (r_state == DONE) ? r_grant : '0;
    assign abort_o       = r_abort;
    assign wrap_o        = r_wrap;
    assign start_count_o = r_start;
    assign busy_o        = (r_state != IDLE);
    assign enable_o      = (r_state == RUN);

endmodule
`default_nettype wire
